// File: rtl/denormalize_stream.sv
// denormalize_stream: rescales serial normalized coefficients by 2^SHIFT with
// saturation to IN_W bits and packs them into ping-pong buffered 4x4 blocks.
// Ports:
//   clk, rst_n (async, active low), clr (sync discard)
//   s_valid/s_ready/s_data : serial coefficient input, raster order
//   m_valid/m_ready/m_block/m_sat : 4x4 block output with saturation flag
module denormalize_stream #(
   parameter int IN_W  = 24,
   parameter int OUT_W = 16,
   parameter int SHIFT = 14
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic signed [OUT_W-1:0] s_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic signed [IN_W-1:0] m_block [0:3][0:3],
   output logic                   m_sat
);

   localparam int PW = OUT_W + SHIFT;

   localparam logic signed [IN_W-1:0] MAX_V =
      {1'b0, {(IN_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MIN_V =
      {1'b1, {(IN_W-1){1'b0}}};

   logic signed [PW-1:0]    wide;
   logic [PW-IN_W:0]        top;
   logic                    ovf;
   logic signed [IN_W-1:0]  scaled;

   logic [1:0]              full;
   logic [1:0]              sat;
   logic                    wr_sel;
   logic                    rd_sel;
   logic [3:0]              wr_cnt;
   logic                    wr;
   logic                    rd;

   logic signed [IN_W-1:0]  mem [0:1][0:3][0:3];

   assign wide = {s_data, {SHIFT{1'b0}}};

   // Value fits in IN_W bits only when every bit from the IN_W sign
   // position upward agrees.
   assign top = wide[PW-1:IN_W-1];
   assign ovf = !((&top) || !(|top));

   assign scaled = ovf ? (wide[PW-1] ? MIN_V : MAX_V)
                       : wide[IN_W-1:0];

   assign s_ready = !full[wr_sel];
   assign m_valid = full[rd_sel];
   assign m_sat   = full[rd_sel] & sat[rd_sel];

   assign wr = s_valid && s_ready;
   assign rd = m_valid && m_ready;

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            m_block[r][c] = mem[rd_sel][r][c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full   <= 2'b00;
         sat    <= 2'b00;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_cnt <= 4'd0;
      end else if (clr) begin
         full   <= 2'b00;
         sat    <= 2'b00;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_cnt <= 4'd0;
      end else begin
         if (wr) begin
            wr_cnt <= wr_cnt + 4'd1;
            // first sample of a block restarts the sticky flag
            sat[wr_sel] <= (wr_cnt == 4'd0) ? ovf
                                            : (sat[wr_sel] | ovf);
            if (wr_cnt == 4'd15) begin
               full[wr_sel] <= 1'b1;
               wr_sel       <= ~wr_sel;
            end
         end
         // a draining buffer is FULL and a filling one is FREE,
         // so these never touch the same full bit
         if (rd) begin
            full[rd_sel] <= 1'b0;
            rd_sel       <= ~rd_sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 4; r++) begin
               for (int c = 0; c < 4; c++) begin
                  mem[b][r][c] <= '0;
               end
            end
         end
      end else if (wr && !clr) begin
         mem[wr_sel][wr_cnt[3:2]][wr_cnt[1:0]] <= scaled;
      end
   end

endmodule
